// File: rtl/adc_to_opfb_hls_deadlock_reporter.sv
// Deadlock reporter for the adc_to_opfb dataflow region: watches per-monitor block
// flags, declares deadlock after TIMEOUT progress-free blocked cycles, offers a one-shot report.
module adc_to_opfb_hls_deadlock_reporter #(
    parameter int N_MON   = 4,
    parameter int TIMEOUT = 1024,
    parameter int IDX_W   = (N_MON > 1) ? $clog2(N_MON) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_MON-1:0] mon_block,
    input  logic             progress,
    input  logic             clear,
    output logic             deadlock,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [N_MON-1:0] report_mask,
    output logic [IDX_W-1:0] report_first_idx,
    output logic [31:0]      report_stamp
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WATCH  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    localparam logic [1:0] S_HELD   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] low_idx;
    logic [31:0]      stamp_cnt;

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        low_idx = '0;
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (mon_block[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stamp_cnt <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            first_idx        <= '0;
            deadlock         <= 1'b0;
            report_valid     <= 1'b0;
            report_mask      <= '0;
            report_first_idx <= '0;
            report_stamp     <= '0;
        end else if (clear) begin
            state        <= S_IDLE;
            cnt          <= '0;
            deadlock     <= 1'b0;
            report_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|mon_block && !progress) begin
                        state     <= S_WATCH;
                        cnt       <= CNT_W'(1);
                        first_idx <= low_idx;
                    end
                end
                S_WATCH: begin
                    if (mon_block == '0 || progress) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state            <= S_REPORT;
                        cnt              <= '0;
                        deadlock         <= 1'b1;
                        report_valid     <= 1'b1;
                        report_mask      <= mon_block;
                        report_first_idx <= first_idx;
                        report_stamp     <= stamp_cnt;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_REPORT: begin
                    if (report_ready) begin
                        state        <= S_HELD;
                        report_valid <= 1'b0;
                    end
                end
                // Only clear (or reset) re-arms after a report has been taken.
                S_HELD: begin
                    state <= S_HELD;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_to_opfb_hls_deadlock_reporter.sv
// Self-checking bench for adc_to_opfb_hls_deadlock_reporter using a run-length
// reference model of the deadlock rules plus directed scenarios.
module tb_adc_to_opfb_hls_deadlock_reporter;

    localparam int N_MON   = 4;
    localparam int TIMEOUT = 8;
    localparam int IDX_W   = 2;

    logic             clock;
    logic             reset;
    logic [N_MON-1:0] mon_block;
    logic             progress;
    logic             clear;
    logic             deadlock;
    logic             report_valid;
    logic             report_ready;
    logic [N_MON-1:0] report_mask;
    logic [IDX_W-1:0] report_first_idx;
    logic [31:0]      report_stamp;

    int checks;
    int errors;

    // Reference model: length of the current blocked, progress-free run.
    int               m_run;
    logic [IDX_W-1:0] m_first;
    logic             m_dead;
    logic             m_valid;
    logic [N_MON-1:0] m_mask;
    logic [IDX_W-1:0] m_rfirst;
    logic [31:0]      m_stamp;
    logic [31:0]      m_cycle;

    adc_to_opfb_hls_deadlock_reporter #(
        .N_MON  (N_MON),
        .TIMEOUT(TIMEOUT),
        .IDX_W  (IDX_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mon_block       (mon_block),
        .progress        (progress),
        .clear           (clear),
        .deadlock        (deadlock),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_mask     (report_mask),
        .report_first_idx(report_first_idx),
        .report_stamp    (report_stamp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [IDX_W-1:0] lowest(input logic [N_MON-1:0] mb);
        for (int i = 0; i < N_MON; i++) begin
            if (mb[i]) return IDX_W'(i);
        end
        return '0;
    endfunction

    function automatic logic [39:0] observed();
        return {deadlock, report_valid, report_mask, report_first_idx, report_stamp};
    endfunction

    function automatic logic [39:0] expected();
        return {m_dead, m_valid, m_mask, m_rfirst, m_stamp};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1ns.
    task automatic tick(input logic [N_MON-1:0] mb, input logic pg, input logic clr, input logic rdy);
        mon_block    = mb;
        progress     = pg;
        clear        = clr;
        report_ready = rdy;
        @(posedge clock);
        if (reset) begin
            m_run = 0; m_first = '0; m_dead = 0; m_valid = 0;
            m_mask = '0; m_rfirst = '0; m_stamp = '0; m_cycle = '0;
        end else begin
            if (clr) begin
                m_dead = 0; m_valid = 0; m_run = 0;
            end else if (m_dead) begin
                if (m_valid && rdy) m_valid = 0;
            end else if (mb != '0 && !pg) begin
                m_run++;
                if (m_run == 1) m_first = lowest(mb);
                if (m_run == TIMEOUT) begin
                    m_dead = 1; m_valid = 1; m_mask = mb;
                    m_rfirst = m_first; m_stamp = m_cycle; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_cycle = m_cycle + 32'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(4'($urandom), 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        reset = 1'b0;
        checks++;
        if (observed() !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, want %h", observed(), 40'h0);
        end
    endtask

    task automatic test_basic_timeout();
        do_reset();
        for (int i = 0; i < 10; i++) tick(4'b0000, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= TIMEOUT; j++) begin
            tick(4'b0100, 1'b0, 1'b0, 1'b0);
            checks++;
            if (deadlock !== (j == TIMEOUT) || report_valid !== (j == TIMEOUT)) begin
                errors++;
                $display("[TB] FAIL basic_latency tick %0d: deadlock=%0b valid=%0b, want %0b",
                         j, deadlock, report_valid, (j == TIMEOUT));
            end
        end
        checks++;
        if ({report_mask, report_first_idx, report_stamp} !== {4'b0100, 2'd2, 32'd17}) begin
            errors++;
            $display("[TB] FAIL basic_fields: mask=%b idx=%0d stamp=%0d, want 0100 2 17",
                     report_mask, report_first_idx, report_stamp);
        end
    endtask

    task automatic test_progress_restart();
        tick(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= 14; j++) begin
            tick(4'b0100, (j == 6), 1'b0, 1'b0);
            checks++;
            if (report_valid !== (j == 14)) begin
                errors++;
                $display("[TB] FAIL progress_restart tick %0d: valid=%0b, want %0b",
                         j, report_valid, (j == 14));
            end
        end
    endtask

    task automatic test_mask_change();
        tick(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= TIMEOUT; j++) tick((j <= 3) ? 4'b0010 : 4'b1010, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({report_valid, report_mask, report_first_idx} !== {1'b1, 4'b1010, 2'd1}) begin
            errors++;
            $display("[TB] FAIL mask_change: valid=%0b mask=%b idx=%0d, want 1 1010 1",
                     report_valid, report_mask, report_first_idx);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            tick(4'b1010, 1'b0, 1'b0, 1'b0);
            checks++;
            if (observed() !== expected() || {report_valid, report_mask, report_first_idx} !== {1'b1, 4'b1010, 2'd1}) begin
                errors++;
                $display("[TB] FAIL backpressure_stable %0d: got %h, want %h", i, observed(), expected());
            end
        end
        tick(4'b1010, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({deadlock, report_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL handshake_drop: deadlock/valid=%b, want 10", {deadlock, report_valid});
        end
        for (int i = 0; i < 2 * TIMEOUT; i++) begin
            tick(4'b1010, 1'b0, 1'b0, 1'($urandom));
            checks++;
            if ({deadlock, report_valid} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL no_second_report %0d: deadlock/valid=%b, want 10", i, {deadlock, report_valid});
            end
        end
    endtask

    task automatic test_clear_with_handshake();
        tick(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int j = 1; j <= TIMEOUT; j++) tick(4'b0001, 1'b0, 1'b0, 1'b0);
        tick(4'b0001, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({deadlock, report_valid} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clear_wins: deadlock/valid=%b, want 00", {deadlock, report_valid});
        end
        for (int j = 1; j <= TIMEOUT; j++) begin
            tick(4'b0001, 1'b0, 1'b0, 1'b0);
            checks++;
            if (report_valid !== (j == TIMEOUT)) begin
                errors++;
                $display("[TB] FAIL rearm_report tick %0d: valid=%0b, want %0b", j, report_valid, (j == TIMEOUT));
            end
        end
    endtask

    task automatic test_stamp_wrap();
        tick(4'b0000, 1'b0, 1'b1, 1'b0);
        force dut.stamp_cnt = 32'hFFFF_FFFC;
        m_cycle = 32'hFFFF_FFFC;
        #1;
        release dut.stamp_cnt;
        for (int j = 1; j <= TIMEOUT; j++) tick(4'b1000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (report_stamp !== 32'd3 || report_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stamp_wrap: stamp=%h valid=%0b, want 00000003 1", report_stamp, report_valid);
        end
    endtask

    task automatic test_reset_mid_watch();
        tick(4'b0000, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) tick(4'b0110, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick(4'b0110, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (observed() !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid_watch: got %h, want 0", observed());
        end
        for (int j = 1; j < TIMEOUT; j++) tick(4'b0110, 1'b0, 1'b0, 1'b0);
        checks++;
        if (report_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_restarts_count: valid=%0b, want 0", report_valid);
        end
    endtask

    task automatic test_random();
        logic [N_MON-1:0] mb;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            mb = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            tick(mb, ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0), 1'($urandom));
            reset = 1'b0;
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h, want %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        mon_block    = '0;
        progress     = 1'b0;
        clear        = 1'b0;
        report_ready = 1'b0;
        m_cycle      = '0;
        test_reset();
        test_basic_timeout();
        test_progress_restart();
        test_mask_change();
        test_backpressure();
        test_clear_with_handshake();
        test_stamp_wrap();
        test_reset_mid_watch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
